// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin arbiter that merges NUM_MASTERS line-wide Wishbone master ports
// onto one downstream master port. A master owns the bus from the grant edge
// until its transaction terminates (ack, retry, abort or watchdog timeout).
// Every termination is followed by exactly one IDLE cycle before the next grant.
//
// Ports
//   CLK, RST           clock; synchronous active-high reset
//   m_cyc/m_stb/m_we   per-master Wishbone controls (bit i = master i)
//   m_adr/m_dat_m/m_sel packed per-master address, write data, byte selects
//   m_dat_s            read data broadcast to all masters
//   m_ack/m_rty        per-master termination
//   s_cyc/s_stb/s_we   downstream controls
//   s_adr/s_dat_m/s_sel downstream address, write data, byte selects
//   s_dat_s            downstream read data
//   s_ack/s_rty        downstream termination
//   grant              index of the owning master (debug/perf)
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter  int NUM_MASTERS = 2,
    parameter  int ADR_W       = 12,
    parameter  int DAT_W       = 128,
    parameter  int TIMEOUT     = 64,
    localparam int SEL_W       = DAT_W / 8,
    localparam int GNT_W       = $clog2(NUM_MASTERS)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_MASTERS-1:0]       m_cyc,
    input  logic [NUM_MASTERS-1:0]       m_stb,
    input  logic [NUM_MASTERS-1:0]       m_we,
    input  logic [NUM_MASTERS*ADR_W-1:0] m_adr,
    input  logic [NUM_MASTERS*DAT_W-1:0] m_dat_m,
    input  logic [NUM_MASTERS*SEL_W-1:0] m_sel,
    output logic [DAT_W-1:0]             m_dat_s,
    output logic [NUM_MASTERS-1:0]       m_ack,
    output logic [NUM_MASTERS-1:0]       m_rty,
    output logic                         s_cyc,
    output logic                         s_stb,
    output logic                         s_we,
    output logic [ADR_W-1:0]             s_adr,
    output logic [DAT_W-1:0]             s_dat_m,
    output logic [SEL_W-1:0]             s_sel,
    input  logic [DAT_W-1:0]             s_dat_s,
    input  logic                         s_ack,
    input  logic                         s_rty,
    output logic [GNT_W-1:0]             grant
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // A zero TIMEOUT disables the watchdog; keep a 1-bit counter that never moves.
    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [0:0]       r_state;
    logic [GNT_W-1:0] r_grant;
    logic [GNT_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [NUM_MASTERS-1:0] w_req;
    logic [GNT_W-1:0]       w_next_grant;
    logic                   w_found;
    logic                   w_own_cyc;
    logic                   w_timeout_hit;
    logic                   w_done;

    logic [ADR_W-1:0] w_adr [NUM_MASTERS];
    logic [DAT_W-1:0] w_dat [NUM_MASTERS];
    logic [SEL_W-1:0] w_sel [NUM_MASTERS];

    genvar gi;
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
        assign w_adr[gi] = m_adr[gi*ADR_W +: ADR_W];
        assign w_dat[gi] = m_dat_m[gi*DAT_W +: DAT_W];
        assign w_sel[gi] = m_sel[gi*SEL_W +: SEL_W];
    end

    assign w_req = m_cyc & m_stb;
    assign grant = r_grant;

    // Scan last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_next_grant = '0;
        w_found      = 1'b0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            if (!w_found && w_req[(int'(r_last) + off) % NUM_MASTERS]) begin
                w_found      = 1'b1;
                w_next_grant = GNT_W'((int'(r_last) + off) % NUM_MASTERS);
            end
        end
    end

    assign w_own_cyc = m_cyc[r_grant];

    // Watchdog fires only when the slave gives no termination of its own;
    // ack and retry both outrank it.
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_MAX) && !s_ack && !s_rty;

    // An abort coinciding with ack is still a completion; either way the bus
    // is released at this edge, so all exits collapse into one condition.
    assign w_done = s_ack || s_rty || w_timeout_hit || !w_own_cyc;

    // Outputs decode from registered state, so the cycle after a sampled
    // reset is always IDLE with every output low.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_m = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_rty   = '0;
        m_dat_s = '0;
        if (r_state == ST_BUSY) begin
            s_cyc          = w_own_cyc && !w_timeout_hit;
            s_stb          = w_own_cyc && m_stb[r_grant] && !w_timeout_hit;
            s_we           = w_own_cyc && m_we[r_grant];
            s_adr          = w_own_cyc ? w_adr[r_grant] : '0;
            s_dat_m        = w_own_cyc ? w_dat[r_grant] : '0;
            s_sel          = w_own_cyc ? w_sel[r_grant] : '0;
            m_ack[r_grant] = s_ack;
            m_rty[r_grant] = s_rty || w_timeout_hit;
            m_dat_s        = s_dat_s;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_last  <= GNT_W'(NUM_MASTERS - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_next_grant;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    if (w_done) begin
                        r_last  <= r_grant;
                        r_state <= ST_IDLE;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Directed bench for wb_rr_arbiter built with 4 masters and an 8-cycle
// watchdog. Each scenario task drives stimulus and compares the DUT outputs
// against hand-computed values. Inputs change 1 ns after the rising edge and
// outputs are compared a further 1 ns later.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    localparam int N     = 4;
    localparam int ADR_W = 12;
    localparam int DAT_W = 128;
    localparam int SEL_W = DAT_W / 8;
    localparam int TO    = 8;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic [N-1:0]           m_cyc, m_stb, m_we;
    logic [N*ADR_W-1:0]     m_adr;
    logic [N*DAT_W-1:0]     m_dat_m;
    logic [N*SEL_W-1:0]     m_sel;
    logic [DAT_W-1:0]       m_dat_s;
    logic [N-1:0]           m_ack, m_rty;
    logic                   s_cyc, s_stb, s_we;
    logic [ADR_W-1:0]       s_adr;
    logic [DAT_W-1:0]       s_dat_m;
    logic [SEL_W-1:0]       s_sel;
    logic [DAT_W-1:0]       s_dat_s;
    logic                   s_ack, s_rty;
    logic [1:0]             grant;

    int checks = 0;
    int errors = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS(N),
        .ADR_W      (ADR_W),
        .DAT_W      (DAT_W),
        .TIMEOUT    (TO)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .m_cyc  (m_cyc),
        .m_stb  (m_stb),
        .m_we   (m_we),
        .m_adr  (m_adr),
        .m_dat_m(m_dat_m),
        .m_sel  (m_sel),
        .m_dat_s(m_dat_s),
        .m_ack  (m_ack),
        .m_rty  (m_rty),
        .s_cyc  (s_cyc),
        .s_stb  (s_stb),
        .s_we   (s_we),
        .s_adr  (s_adr),
        .s_dat_m(s_dat_m),
        .s_sel  (s_sel),
        .s_dat_s(s_dat_s),
        .s_ack  (s_ack),
        .s_rty  (s_rty),
        .grant  (grant)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [ADR_W-1:0] adr,
                           input logic [DAT_W-1:0] dat, input logic [SEL_W-1:0] sel);
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_we[i]  = we;
        m_adr[i*ADR_W +: ADR_W] = adr;
        m_dat_m[i*DAT_W +: DAT_W] = dat;
        m_sel[i*SEL_W +: SEL_W] = sel;
    endtask

    task automatic clr_req(input int i);
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
        m_we[i]  = 1'b0;
    endtask

    task automatic do_reset();
        RST     = 1'b1;
        m_cyc   = '0;
        m_stb   = '0;
        m_we    = '0;
        m_adr   = '0;
        m_dat_m = '0;
        m_sel   = '0;
        s_dat_s = '0;
        s_ack   = 1'b0;
        s_rty   = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_cyc, s_stb, s_we} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl: got %b expected 000", {s_cyc, s_stb, s_we});
        end
        checks++;
        if ({m_ack, m_rty} !== 8'h00) begin
            errors++; $display("FAIL reset_term: got %h expected 00", {m_ack, m_rty});
        end
        checks++;
        if (grant !== 2'd0) begin
            errors++; $display("FAIL reset_grant: got %0d expected 0", grant);
        end
        checks++;
        if (s_adr !== '0 || s_sel !== '0 || m_dat_s !== '0) begin
            errors++; $display("FAIL reset_bus: adr %h sel %h dat_s %h expected all 0", s_adr, s_sel, m_dat_s);
        end
    endtask

    task automatic test_single_read();
        logic [DAT_W-1:0] rd;
        rd = {4{32'hDEADBEEF}};
        do_reset();
        set_req(1, 1'b0, 12'h0A3, '0, '1);
        #1;
        checks++;
        if (s_stb !== 1'b0) begin
            errors++; $display("FAIL single_pre_stb: got %b expected 0", s_stb);
        end
        tick();
        checks++;
        if (s_stb !== 1'b1 || s_adr !== 12'h0A3 || s_we !== 1'b0) begin
            errors++; $display("FAIL single_issue: stb %b adr %h we %b expected 1 0a3 0", s_stb, s_adr, s_we);
        end
        checks++;
        if (grant !== 2'd1) begin
            errors++; $display("FAIL single_grant: got %0d expected 1", grant);
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (m_ack !== 4'b0000) begin
                errors++; $display("FAIL single_wait_ack: cycle %0d got %b expected 0000", c, m_ack);
            end
            tick();
        end
        s_ack   = 1'b1;
        s_dat_s = rd;
        #1;
        checks++;
        if (m_ack !== 4'b0010) begin
            errors++; $display("FAIL single_ack: got %b expected 0010", m_ack);
        end
        checks++;
        if (m_dat_s !== rd) begin
            errors++; $display("FAIL single_data: got %h expected %h", m_dat_s, rd);
        end
        tick();
        clr_req(1);
        s_ack = 1'b0;
        #1;
        checks++;
        if (s_stb !== 1'b0 || m_ack !== 4'b0000) begin
            errors++; $display("FAIL single_after: stb %b ack %b expected 0 0000", s_stb, m_ack);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_req(0, 1'b0, 12'h010, '0, '1);
        set_req(1, 1'b0, 12'h020, '0, '1);
        tick();
        checks++;
        if (grant !== 2'd0 || s_adr !== 12'h010 || s_stb !== 1'b1) begin
            errors++; $display("FAIL simul_first: grant %0d adr %h stb %b expected 0 010 1", grant, s_adr, s_stb);
        end
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_ack !== 4'b0001) begin
            errors++; $display("FAIL simul_ack0: got %b expected 0001", m_ack);
        end
        tick();
        clr_req(0);
        s_ack = 1'b0;
        #1;
        checks++;
        if (s_stb !== 1'b0) begin
            errors++; $display("FAIL simul_idle_gap: stb %b expected 0", s_stb);
        end
        tick();
        checks++;
        if (grant !== 2'd1 || s_adr !== 12'h020 || s_stb !== 1'b1) begin
            errors++; $display("FAIL simul_second: grant %0d adr %h stb %b expected 1 020 1", grant, s_adr, s_stb);
        end
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_ack !== 4'b0010) begin
            errors++; $display("FAIL simul_ack1: got %b expected 0010", m_ack);
        end
        tick();
        clr_req(1);
        s_ack = 1'b0;
        #1;
    endtask

    task automatic test_fairness();
        int exp_g;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, ADR_W'(12'h100 + i), '0, '1);
        for (int t = 0; t < 12; t++) begin
            exp_g = t % N;
            tick();
            checks++;
            if (grant !== 2'(exp_g) || s_adr !== ADR_W'(12'h100 + exp_g)) begin
                errors++; $display("FAIL fair_grant: txn %0d grant %0d adr %h expected %0d", t, grant, s_adr, exp_g);
            end
            s_ack = 1'b1;
            #1;
            checks++;
            if (m_ack !== 4'(1 << exp_g)) begin
                errors++; $display("FAIL fair_ack: txn %0d got %b expected %b", t, m_ack, 4'(1 << exp_g));
            end
            tick();
            s_ack = 1'b0;
            #1;
            checks++;
            if (s_stb !== 1'b0) begin
                errors++; $display("FAIL fair_gap: txn %0d stb %b expected 0", t, s_stb);
            end
        end
        for (int i = 0; i < N; i++) clr_req(i);
        tick();
    endtask

    task automatic test_write();
        logic [DAT_W-1:0] wd;
        wd = {16{8'h11}};
        do_reset();
        set_req(0, 1'b1, 12'h3C0, wd, 16'h00F0);
        tick();
        checks++;
        if (s_we !== 1'b1 || s_sel !== 16'h00F0 || s_cyc !== 1'b1) begin
            errors++; $display("FAIL write_ctl: we %b sel %h cyc %b expected 1 00f0 1", s_we, s_sel, s_cyc);
        end
        checks++;
        if (s_dat_m !== wd) begin
            errors++; $display("FAIL write_data: got %h expected %h", s_dat_m, wd);
        end
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_ack !== 4'b0001) begin
            errors++; $display("FAIL write_ack: got %b expected 0001", m_ack);
        end
        tick();
        clr_req(0);
        s_ack = 1'b0;
        #1;
        checks++;
        if (m_ack !== 4'b0000 || s_we !== 1'b0) begin
            errors++; $display("FAIL write_after: ack %b we %b expected 0000 0", m_ack, s_we);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        set_req(0, 1'b0, 12'h055, '0, '1);
        set_req(1, 1'b0, 12'h066, '0, '1);
        tick();
        for (int c = 1; c < TO; c++) begin
            checks++;
            if (m_rty !== 4'b0000 || s_stb !== 1'b1) begin
                errors++; $display("FAIL wdog_wait: busy cycle %0d rty %b stb %b expected 0000 1", c, m_rty, s_stb);
            end
            tick();
        end
        checks++;
        if (m_rty !== 4'b0001) begin
            errors++; $display("FAIL wdog_rty: got %b expected 0001", m_rty);
        end
        checks++;
        if (s_stb !== 1'b0 || s_cyc !== 1'b0) begin
            errors++; $display("FAIL wdog_stb: stb %b cyc %b expected 0 0", s_stb, s_cyc);
        end
        tick();
        clr_req(0);
        #1;
        checks++;
        if (s_stb !== 1'b0 || m_rty !== 4'b0000) begin
            errors++; $display("FAIL wdog_idle: stb %b rty %b expected 0 0000", s_stb, m_rty);
        end
        tick();
        checks++;
        if (grant !== 2'd1 || s_adr !== 12'h066 || s_stb !== 1'b1) begin
            errors++; $display("FAIL wdog_next: grant %0d adr %h stb %b expected 1 066 1", grant, s_adr, s_stb);
        end
        s_ack = 1'b1;
        tick();
        clr_req(1);
        s_ack = 1'b0;
        #1;
    endtask

    task automatic test_abort_reset();
        do_reset();
        set_req(1, 1'b0, 12'h0B0, '0, '1);
        tick();
        checks++;
        if (s_stb !== 1'b1 || grant !== 2'd1) begin
            errors++; $display("FAIL abort_start: stb %b grant %0d expected 1 1", s_stb, grant);
        end
        tick();
        clr_req(1);
        #1;
        checks++;
        if (s_stb !== 1'b0 || s_cyc !== 1'b0 || m_ack !== 4'b0000 || m_rty !== 4'b0000) begin
            errors++; $display("FAIL abort_drop: stb %b cyc %b ack %b rty %b expected all 0", s_stb, s_cyc, m_ack, m_rty);
        end
        tick();
        set_req(3, 1'b0, 12'h0C0, '0, '1);
        #1;
        checks++;
        if (s_stb !== 1'b0) begin
            errors++; $display("FAIL abort_idle: stb %b expected 0", s_stb);
        end
        tick();
        checks++;
        if (grant !== 2'd3 || s_stb !== 1'b1) begin
            errors++; $display("FAIL rst_busy: grant %0d stb %b expected 3 1", grant, s_stb);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        set_req(0, 1'b0, 12'h0D0, '0, '1);
        s_ack = 1'b1;
        #1;
        checks++;
        if (s_stb !== 1'b0 || s_cyc !== 1'b0 || m_ack !== 4'b0000 || grant !== 2'd0) begin
            errors++; $display("FAIL rst_zero: stb %b cyc %b ack %b grant %0d expected 0 0 0000 0", s_stb, s_cyc, m_ack, grant);
        end
        s_ack = 1'b0;
        tick();
        checks++;
        if (grant !== 2'd0 || s_adr !== 12'h0D0) begin
            errors++; $display("FAIL rst_rearb: grant %0d adr %h expected 0 0d0", grant, s_adr);
        end
        s_ack = 1'b1;
        tick();
        clr_req(0);
        clr_req(3);
        s_ack = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fairness();
        test_write();
        test_watchdog();
        test_abort_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
